// File: rtl/reg_bypass_source_if.sv
// Bus between the ID/EX boundary and the bypass producer.
// Carries the issuing instruction, the EX/MM result values and the
// per-stage bypass triples plus the register-file write port.
`ifndef ACCESS_TYPE_NONE
`define ACCESS_TYPE_NONE 2'b00
`define ACCESS_TYPE_R2R  2'b01
`define ACCESS_TYPE_M2R  2'b10
`define ACCESS_TYPE_R2M  2'b11
`endif

// Handshake: there is no ready signal. An instruction is captured into EX
// on a rising edge where id_valid is high, unless load_use_stall,
// mem_stall or flush is high in that same cycle. ID must hold its
// instruction while either stall is reported.
interface reg_bypass_source_if;
  logic        id_valid;
  logic [4:0]  id_dest_addr;
  logic [1:0]  id_access_type;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] ex_result;
  logic [31:0] mm_data;
  logic        mm_data_valid;
  logic        flush;

  logic [4:0]  addr_to_ex;
  logic [1:0]  access_type_to_ex;
  logic [31:0] val_to_ex;
  logic [4:0]  addr_to_mm;
  logic [1:0]  access_type_to_mm;
  logic [31:0] val_to_mm;
  logic [4:0]  addr_to_wb;
  logic [31:0] val_to_wb;
  logic        wb_we;
  logic        load_use_stall;
  logic        mem_stall;

  modport master (
    output id_valid, id_dest_addr, id_access_type, id_rs_addr, id_rt_addr,
    output ex_result, mm_data, mm_data_valid, flush,
    input  addr_to_ex, access_type_to_ex, val_to_ex,
    input  addr_to_mm, access_type_to_mm, val_to_mm,
    input  addr_to_wb, val_to_wb, wb_we, load_use_stall, mem_stall
  );

  modport slave (
    input  id_valid, id_dest_addr, id_access_type, id_rs_addr, id_rt_addr,
    input  ex_result, mm_data, mm_data_valid, flush,
    output addr_to_ex, access_type_to_ex, val_to_ex,
    output addr_to_mm, access_type_to_mm, val_to_mm,
    output addr_to_wb, val_to_wb, wb_we, load_use_stall, mem_stall
  );
endinterface

// File: rtl/reg_bypass_source.sv
// Producer side of the register-bypass network: EX/MM/WB tracking of
// destination, access type and value, load-use / memory stall detection
// and the register-file write port.
module reg_bypass_source (
  input logic                clk,
  input logic                rst,
  reg_bypass_source_if.slave bus
);
  localparam logic [1:0] AT_NONE = `ACCESS_TYPE_NONE;
  localparam logic [1:0] AT_R2R  = `ACCESS_TYPE_R2R;
  localparam logic [1:0] AT_M2R  = `ACCESS_TYPE_M2R;
  localparam logic [1:0] AT_R2M  = `ACCESS_TYPE_R2M;

  logic [4:0]  ex_addr_q, ex_addr_d;
  logic [1:0]  ex_type_q, ex_type_d;
  logic [4:0]  mm_addr_q, mm_addr_d;
  logic [1:0]  mm_type_q, mm_type_d;
  logic [31:0] mm_val_q,  mm_val_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [1:0]  wb_type_q, wb_type_d;
  logic [31:0] wb_val_q,  wb_val_d;

  logic        id_take;
  logic [4:0]  id_addr_n;
  logic [1:0]  id_type_n;
  logic        ex_late;
  logic        mm_late;
  logic        rs_hit;
  logic        rt_hit;
  logic        lu_stall;
  logic        m_stall;
  logic [31:0] mm_fwd_val;
  logic [31:0] ex_promote_val;

  // Writes to r0 and non-issues both become an empty EX entry.
  assign id_take   = bus.id_valid && (bus.id_dest_addr != 5'd0);
  assign id_addr_n = id_take ? bus.id_dest_addr : 5'd0;
  assign id_type_n = id_take ? bus.id_access_type : AT_NONE;

  // "Late" values are only available in MM, not in EX.
  assign ex_late = (ex_type_q == AT_M2R) || (ex_type_q == AT_R2M);
  assign mm_late = (mm_type_q == AT_M2R) || (mm_type_q == AT_R2M);

  assign rs_hit   = (bus.id_rs_addr != 5'd0) && (bus.id_rs_addr == ex_addr_q);
  assign rt_hit   = (bus.id_rt_addr != 5'd0) && (bus.id_rt_addr == ex_addr_q);
  assign lu_stall = ex_late && (ex_addr_q != 5'd0) && (rs_hit || rt_hit);
  assign m_stall  = mm_late && !bus.mm_data_valid;

  assign mm_fwd_val     = mm_late ? bus.mm_data : mm_val_q;
  assign ex_promote_val = (ex_type_q == AT_R2R) ? bus.ex_result : 32'd0;

  assign bus.addr_to_ex        = ex_addr_q;
  assign bus.access_type_to_ex = ex_type_q;
  assign bus.val_to_ex         = bus.ex_result;
  assign bus.addr_to_mm        = mm_addr_q;
  // An invalid late value is hidden so consumers never forward it.
  assign bus.access_type_to_mm = m_stall ? AT_NONE : mm_type_q;
  assign bus.val_to_mm         = mm_fwd_val;
  assign bus.addr_to_wb        = wb_addr_q;
  assign bus.val_to_wb         = wb_val_q;
  assign bus.wb_we             = (wb_type_q != AT_NONE) && (wb_addr_q != 5'd0);
  assign bus.load_use_stall    = lu_stall;
  assign bus.mem_stall         = m_stall;

  // Next-state selection: mem_stall > flush > load_use_stall > shift.
  always_comb begin
    ex_addr_d = id_addr_n;
    ex_type_d = id_type_n;
    mm_addr_d = ex_addr_q;
    mm_type_d = ex_type_q;
    mm_val_d  = ex_promote_val;
    wb_addr_d = mm_addr_q;
    wb_type_d = mm_type_q;
    wb_val_d  = mm_fwd_val;
    if (m_stall) begin
      // EX and MM hold; WB takes a bubble so the last write is not repeated.
      ex_addr_d = bus.flush ? 5'd0 : ex_addr_q;
      ex_type_d = bus.flush ? AT_NONE : ex_type_q;
      mm_addr_d = mm_addr_q;
      mm_type_d = mm_type_q;
      mm_val_d  = mm_val_q;
      wb_addr_d = 5'd0;
      wb_type_d = AT_NONE;
      wb_val_d  = 32'd0;
    end else if (bus.flush) begin
      // The instruction in EX is killed along with the one entering EX.
      ex_addr_d = 5'd0;
      ex_type_d = AT_NONE;
      mm_addr_d = 5'd0;
      mm_type_d = AT_NONE;
      mm_val_d  = 32'd0;
    end else if (lu_stall) begin
      // Bubble into EX; the ID instruction is re-offered next cycle.
      ex_addr_d = 5'd0;
      ex_type_d = AT_NONE;
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_addr_q <= 5'd0;
      ex_type_q <= AT_NONE;
      mm_addr_q <= 5'd0;
      mm_type_q <= AT_NONE;
      mm_val_q  <= 32'd0;
      wb_addr_q <= 5'd0;
      wb_type_q <= AT_NONE;
      wb_val_q  <= 32'd0;
    end else begin
      ex_addr_q <= ex_addr_d;
      ex_type_q <= ex_type_d;
      mm_addr_q <= mm_addr_d;
      mm_type_q <= mm_type_d;
      mm_val_q  <= mm_val_d;
      wb_addr_q <= wb_addr_d;
      wb_type_q <= wb_type_d;
      wb_val_q  <= wb_val_d;
    end
  end
endmodule

// File: tb/tb_reg_bypass_source.sv
// Bench for reg_bypass_source: per-cycle vector table for the pipeline
// scenarios, hand sequences for memory wait and async reset, and a
// register-file write scoreboard.
module tb_reg_bypass_source;
  localparam logic [1:0] TN  = 2'b00;
  localparam logic [1:0] TRR = 2'b01;
  localparam logic [1:0] TMR = 2'b10;

  typedef struct {
    logic v; logic [4:0] d; logic [1:0] t; logic [4:0] rs; logic [4:0] rt;
    logic [31:0] exr; logic [31:0] mmd; logic mmv; logic fl;
    logic [4:0] aex; logic [1:0] tex; logic [4:0] amm; logic [1:0] tmm; logic [31:0] vmm;
    logic [4:0] awb; logic [31:0] vwb; logic we; logic lus; logic ms;
    logic psh; logic [4:0] pa; logic [31:0] pd;
  } vec_t;

  logic clk;
  logic rst;
  reg_bypass_source_if bus ();

  reg_bypass_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk;
  int n_pass;
  logic [36:0] exp_q[$];
  vec_t tbl[17];
  vec_t mv;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, check the same-cycle outputs, then clock.
  task automatic apply(input vec_t x);
    bus.id_valid       = x.v;
    bus.id_dest_addr   = x.d;
    bus.id_access_type = x.t;
    bus.id_rs_addr     = x.rs;
    bus.id_rt_addr     = x.rt;
    bus.ex_result      = x.exr;
    bus.mm_data        = x.mmd;
    bus.mm_data_valid  = x.mmv;
    bus.flush          = x.fl;
    if (x.psh) exp_q.push_back({x.pa, x.pd});
    #1;
    chk("addr_to_ex", {27'd0, bus.addr_to_ex}, {27'd0, x.aex});
    chk("access_type_to_ex", {30'd0, bus.access_type_to_ex}, {30'd0, x.tex});
    chk("val_to_ex", bus.val_to_ex, x.exr);
    chk("addr_to_mm", {27'd0, bus.addr_to_mm}, {27'd0, x.amm});
    chk("access_type_to_mm", {30'd0, bus.access_type_to_mm}, {30'd0, x.tmm});
    chk("val_to_mm", bus.val_to_mm, x.vmm);
    chk("addr_to_wb", {27'd0, bus.addr_to_wb}, {27'd0, x.awb});
    chk("val_to_wb", bus.val_to_wb, x.vwb);
    chk("wb_we", {31'd0, bus.wb_we}, {31'd0, x.we});
    chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, x.lus});
    chk("mem_stall", {31'd0, bus.mem_stall}, {31'd0, x.ms});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " addr_to_ex"}, {27'd0, bus.addr_to_ex}, 32'd0);
    chk({tag, " access_type_to_ex"}, {30'd0, bus.access_type_to_ex}, 32'd0);
    chk({tag, " val_to_ex"}, bus.val_to_ex, bus.ex_result === 32'hx ? 32'd0 : 32'h5a5a5a5a);
    chk({tag, " addr_to_mm"}, {27'd0, bus.addr_to_mm}, 32'd0);
    chk({tag, " access_type_to_mm"}, {30'd0, bus.access_type_to_mm}, 32'd0);
    chk({tag, " val_to_mm"}, bus.val_to_mm, 32'd0);
    chk({tag, " addr_to_wb"}, {27'd0, bus.addr_to_wb}, 32'd0);
    chk({tag, " val_to_wb"}, bus.val_to_wb, 32'd0);
    chk({tag, " wb_we"}, {31'd0, bus.wb_we}, 32'd0);
    chk({tag, " load_use_stall"}, {31'd0, bus.load_use_stall}, 32'd0);
    chk({tag, " mem_stall"}, {31'd0, bus.mem_stall}, 32'd0);
  endtask

  // Scoreboard: every cycle with wb_we high is one register-file write.
  always @(negedge clk) begin
    if (!rst && bus.wb_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=%h expected no write", bus.addr_to_wb, bus.val_to_wb);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.addr_to_wb, bus.val_to_wb} === e) n_pass++;
        else $display("FAIL rf_write: got r%0d=%h expected r%0d=%h", bus.addr_to_wb, bus.val_to_wb, e[36:32], e[31:0]);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    // v,d,t,rs,rt,exr,mmd,mmv,fl | aex,tex,amm,tmm,vmm,awb,vwb,we,lus,ms | psh,pa,pd
    // back-to-back R2R: r3 then r4
    tbl[0]  = '{1'b1,5'd3,TRR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd3,32'h11};
    tbl[1]  = '{1'b1,5'd4,TRR,5'd0,5'd0,32'h11,32'h0,1'b0,1'b0, 5'd3,TRR,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd4,32'h22};
    tbl[2]  = '{1'b0,5'd0,TN,5'd0,5'd0,32'h22,32'h0,1'b0,1'b0, 5'd4,TRR,5'd3,TRR,32'h11,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[3]  = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd4,TRR,32'h22,5'd3,32'h11,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[4]  = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd4,32'h22,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    // load-use: M2R r5, consumer reads rs=5
    tbl[5]  = '{1'b1,5'd5,TMR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF};
    tbl[6]  = '{1'b1,5'd6,TRR,5'd5,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd5,TMR,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0};
    tbl[7]  = '{1'b1,5'd6,TRR,5'd5,5'd0,32'h0,32'hDEADBEEF,1'b1,1'b0, 5'd0,TN,5'd5,TMR,32'hDEADBEEF,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd6,32'h66};
    tbl[8]  = '{1'b0,5'd0,TN,5'd0,5'd0,32'h66,32'h0,1'b0,1'b0, 5'd6,TRR,5'd0,TN,32'h0,5'd5,32'hDEADBEEF,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[9]  = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd6,TRR,32'h66,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    // destination r0
    tbl[10] = '{1'b1,5'd0,TRR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd6,32'h66,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[11] = '{1'b0,5'd0,TN,5'd0,5'd0,32'hFFFF,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    // flush while r7 in EX, r8 in MM
    tbl[12] = '{1'b1,5'd8,TRR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd8,32'h88};
    tbl[13] = '{1'b1,5'd7,TRR,5'd0,5'd0,32'h88,32'h0,1'b0,1'b0, 5'd8,TRR,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[14] = '{1'b1,5'd9,TRR,5'd0,5'd0,32'h77,32'h0,1'b0,1'b1, 5'd7,TRR,5'd8,TRR,32'h88,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[15] = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd8,32'h88,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    tbl[16] = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};

    // reset
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_dest_addr = 5'd0; bus.id_access_type = TN;
    bus.id_rs_addr = 5'd0; bus.id_rt_addr = 5'd0; bus.ex_result = 32'h5a5a5a5a;
    bus.mm_data = 32'h0; bus.mm_data_valid = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // memory wait: M2R r10 sits in MM for 3 invalid cycles with r11 behind it
    mv = '{1'b1,5'd10,TMR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd10,32'hCAFE0010};
    apply(mv);
    mv = '{1'b1,5'd11,TRR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd10,TMR,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b1,5'd11,32'hBB};
    apply(mv);
    for (int k = 0; k < 3; k++) begin
      mv = '{1'b1,5'd12,TRR,5'd0,5'd0,32'hBB,32'h1234,1'b0,1'b0, 5'd11,TRR,5'd10,TN,32'h1234,5'd0,32'h0,1'b0,1'b0,1'b1, 1'b0,5'd0,32'h0};
      mv.mmd = $urandom_range(32'h0000_ffff, 32'h0000_0100);
      mv.vmm = mv.mmd;
      apply(mv);
    end
    mv = '{1'b0,5'd0,TN,5'd0,5'd0,32'hBB,32'hCAFE0010,1'b1,1'b0, 5'd11,TRR,5'd10,TMR,32'hCAFE0010,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    mv = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd11,TRR,32'hBB,5'd10,32'hCAFE0010,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    mv = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd11,32'hBB,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    mv = '{1'b0,5'd0,TN,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);

    // async reset with all three stages full (r12 in WB is never written)
    mv = '{1'b1,5'd12,TRR,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0, 5'd0,TN,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    mv = '{1'b1,5'd13,TRR,5'd0,5'd0,32'h12,32'h0,1'b0,1'b0, 5'd12,TRR,5'd0,TN,32'h0,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    mv = '{1'b1,5'd14,TRR,5'd0,5'd0,32'h13,32'h0,1'b0,1'b0, 5'd13,TRR,5'd12,TRR,32'h12,5'd0,32'h0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    apply(mv);
    bus.id_valid = 1'b0; bus.id_dest_addr = 5'd0; bus.id_access_type = TN;
    bus.ex_result = 32'h5a5a5a5a;
    #1;
    chk("full addr_to_ex", {27'd0, bus.addr_to_ex}, 32'd14);
    chk("full addr_to_mm", {27'd0, bus.addr_to_mm}, 32'd13);
    chk("full wb_we", {31'd0, bus.wb_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("post_reset");

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
